ppu_vram_ctrl: RTL and testbench

Downstream memory stage of the PPU. It consumes the PPU memory-access strobes (addr, data_out, read_request, write_request) and returns read data on the PPU data_in lane. It decodes the 14-bit PPU address space and routes each access to one of three places:
- the cartridge CHR bus ($0000-$1FFF), via a req/ack handshake;
- internal 2 KB nametable RAM ($2000-$3EFF), with cartridge-selected mirroring;
- internal 32x6 palette RAM ($3F00-$3FFF).

---
 rtl/ppu_pkg.sv | 28 ++
 rtl/ppu_addr_decode.sv | 41 ++++
 rtl/ppu_vram_ctrl.sv | 151 +++++++++++++++
 tb/tb_ppu_vram_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared encodings for the PPU memory path: mirroring modes, controller FSM
// states and address-region constants.
package ppu_pkg;

  typedef enum logic [1:0] {
    MIR_HORZ   = 2'd0,
    MIR_VERT   = 2'd1,
    MIR_SCR_LO = 2'd2,
    MIR_SCR_HI = 2'd3
  } mirror_t;

  typedef enum logic [2:0] {
    IDLE,
    INT_ACC,
    INT_DONE,
    CHR_REQ,
    CHR_DONE
  } state_t;

  typedef enum logic [1:0] {
    RGN_CHR,
    RGN_NT,
    RGN_PAL
  } region_t;

  localparam logic [5:0] PAL_BASE = 6'h3F;

endpackage

// File: rtl/ppu_addr_decode.sv
// Combinational PPU address decode: region select, mirrored nametable index
// and palette index with the $3F1x backdrop aliasing.
module ppu_addr_decode
  import ppu_pkg::*;
#(
  parameter int unsigned NT_AW = 11
) (
  input  logic [13:0]      addr,
  input  logic [1:0]       mirror_mode,
  output region_t          region,
  output logic [NT_AW-1:0] nt_idx,
  output logic [4:0]       pal_idx
);

  logic nt_page;

  always_comb begin
    if (!addr[13])
      region = RGN_CHR;
    else if (addr[13:8] == PAL_BASE)
      region = RGN_PAL;
    else
      region = RGN_NT;
  end

  always_comb begin
    nt_page = 1'b0;
    case (mirror_t'(mirror_mode))
      MIR_HORZ:   nt_page = addr[11];
      MIR_VERT:   nt_page = addr[10];
      MIR_SCR_LO: nt_page = 1'b0;
      MIR_SCR_HI: nt_page = 1'b1;
      default:    nt_page = 1'b0;
    endcase
  end

  assign nt_idx  = {nt_page, addr[NT_AW-2:0]};
  // Entries 0 of each sprite palette share the background palette slots.
  assign pal_idx = {addr[4] & (addr[1:0] != 2'b00), addr[3:0]};

endmodule

// File: rtl/ppu_vram_ctrl.sv
// PPU memory stage: routes PPU accesses to CHR bus, nametable RAM or palette RAM.
// Build option CHR_RAM_EN: CHR writes use the cartridge handshake (CHR-RAM).
module ppu_vram_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned NT_AW = 11,
  parameter int unsigned PAL_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] addr,
  input  logic [7:0]  wdata,
  input  logic        read_request,
  input  logic        write_request,
  output logic [7:0]  rdata,
  output logic        rd_valid,
  output logic        busy,
  input  logic [1:0]  mirror_mode,
  output logic [12:0] chr_addr,
  output logic [7:0]  chr_wdata,
  output logic        chr_rd,
  output logic        chr_wr,
  input  logic [7:0]  chr_rdata,
  input  logic        chr_ack
);

`ifdef CHR_RAM_EN
  localparam bit CHR_WR_HS = 1'b1;
`else
  localparam bit CHR_WR_HS = 1'b0;
`endif

  state_t            state, state_next;
  logic [13:0]       acc_addr;
  logic [7:0]        acc_wdata;
  logic              acc_wr;
  region_t           region;
  logic [NT_AW-1:0]  nt_idx;
  logic [4:0]        pal_idx;

  logic [7:0]        nt_ram  [2**NT_AW];
  logic [PAL_W-1:0]  pal_ram [32];

  ppu_addr_decode #(.NT_AW(NT_AW)) u_decode (
    .addr        (acc_addr),
    .mirror_mode (mirror_mode),
    .region      (region),
    .nt_idx      (nt_idx),
    .pal_idx     (pal_idx)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (read_request || write_request) begin
          if (addr[13])
            state_next = INT_ACC;
          else if (!write_request || CHR_WR_HS)
            state_next = CHR_REQ;
        end
      end
      INT_ACC:  state_next = INT_DONE;
      INT_DONE: state_next = IDLE;
      CHR_REQ:  if (chr_ack) state_next = CHR_DONE;
      CHR_DONE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // rd_valid is registered at the end of the access cycle so it is visible
  // during INT_DONE / CHR_DONE together with the new rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_wr    <= 1'b0;
      rdata     <= '0;
      rd_valid  <= 1'b0;
      chr_addr  <= '0;
      chr_rd    <= 1'b0;
`ifdef CHR_RAM_EN
      chr_wr    <= 1'b0;
      chr_wdata <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (read_request || write_request) begin
            acc_addr  <= addr;
            acc_wdata <= wdata;
            acc_wr    <= write_request;
            if (state_next == CHR_REQ) begin
              chr_addr <= addr[12:0];
              chr_rd   <= !write_request;
`ifdef CHR_RAM_EN
              chr_wr    <= write_request;
              chr_wdata <= wdata;
`endif
            end
          end
        end
        INT_ACC: begin
          if (!acc_wr) begin
            rd_valid <= 1'b1;
            if (region == RGN_PAL)
              rdata <= {{(8-PAL_W){1'b0}}, pal_ram[pal_idx]};
            else
              rdata <= nt_ram[nt_idx];
          end
        end
        CHR_REQ: begin
          if (chr_ack) begin
            chr_rd <= 1'b0;
`ifdef CHR_RAM_EN
            chr_wr <= 1'b0;
`endif
            if (!acc_wr) begin
              rdata    <= chr_rdata;
              rd_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifndef CHR_RAM_EN
  assign chr_wr    = 1'b0;
  assign chr_wdata = '0;
`endif

  always_ff @(posedge clk) begin
    if (state == INT_ACC && acc_wr) begin
      if (region == RGN_PAL)
        pal_ram[pal_idx] <= acc_wdata[PAL_W-1:0];
      else
        nt_ram[nt_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Self-checking bench for ppu_vram_ctrl against an address-arithmetic VRAM model.
module tb_ppu_vram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] addr;
  logic [7:0]  wdata;
  logic        read_request, write_request;
  logic [7:0]  rdata;
  logic        rd_valid, busy;
  logic [1:0]  mirror_mode;
  logic [12:0] chr_addr;
  logic [7:0]  chr_wdata;
  logic        chr_rd, chr_wr;
  logic [7:0]  chr_rdata;
  logic        chr_ack;

  int checks = 0;
  int failures = 0;

  ppu_vram_ctrl #(.NT_AW(11), .PAL_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .read_request  (read_request),
    .write_request (write_request),
    .rdata         (rdata),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .mirror_mode   (mirror_mode),
    .chr_addr      (chr_addr),
    .chr_wdata     (chr_wdata),
    .chr_rd        (chr_rd),
    .chr_wr        (chr_wr),
    .chr_rdata     (chr_rdata),
    .chr_ack       (chr_ack)
  );

  initial forever #20 clk = ~clk;

  // Reference model: 2 KB physical nametable and 32-entry palette.
  logic [7:0] m_nt  [2048];
  bit         m_nt_ok [2048];
  logic [5:0] m_pal [32];
  bit         m_pal_ok [32];

  function automatic int nt_phys(input logic [13:0] a, input logic [1:0] m);
    int page;
    int phys;
    page = (int'(a) / 1024) % 4;
    case (m)
      2'd0:    phys = page / 2;
      2'd1:    phys = page % 2;
      2'd2:    phys = 0;
      default: phys = 1;
    endcase
    return phys * 1024 + int'(a) % 1024;
  endfunction

  function automatic int pal_phys(input logic [13:0] a);
    int p;
    p = int'(a) % 32;
    if (p % 4 == 0 && p >= 16) p = p - 16;
    return p;
  endfunction

  task automatic model_write(input logic [13:0] a, input logic [7:0] d, input logic [1:0] m);
    if (a >= 14'h3F00) begin
      m_pal[pal_phys(a)]    = d[5:0];
      m_pal_ok[pal_phys(a)] = 1'b1;
    end else if (a >= 14'h2000) begin
      m_nt[nt_phys(a, m)]    = d;
      m_nt_ok[nt_phys(a, m)] = 1'b1;
    end
  endtask

  task automatic model_read(input logic [13:0] a, input logic [1:0] m,
                            output bit known, output logic [7:0] v);
    if (a >= 14'h3F00) begin
      known = m_pal_ok[pal_phys(a)];
      v     = {2'b00, m_pal[pal_phys(a)]};
    end else begin
      known = m_nt_ok[nt_phys(a, m)];
      v     = m_nt[nt_phys(a, m)];
    end
  endtask

  // Results of the most recent access.
  logic [7:0] r_got;
  int         r_vcount, r_vlat, r_req;
  bit         r_addr_ok, r_wr_seen, r_busy_seen, r_timeout;

  // Issues one strobe and plays cartridge: ack in request cycle ack_delay+1.
  // k counts cycles from the accept cycle (k = 0).
  task automatic access(input logic [13:0] a, input logic [7:0] d, input bit wr, input bit rd,
                        input int ack_delay, input logic [7:0] cd,
                        input bit inject, input logic [7:0] inj_d);
    bit done;
    r_vcount = 0; r_vlat = -1; r_req = 0; r_addr_ok = 1'b1;
    r_wr_seen = 1'b0; r_busy_seen = 1'b0; r_timeout = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    addr = a; wdata = d; write_request = wr; read_request = rd;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rd_valid) begin
        r_vcount++;
        if (r_vlat < 0) r_vlat = k;
        r_got = rdata;
      end
      if (busy) r_busy_seen = 1'b1;
      if (chr_wr) r_wr_seen = 1'b1;
      if (chr_rd || chr_wr) begin
        r_req++;
        if (chr_addr !== a[12:0]) r_addr_ok = 1'b0;
        if (r_req == ack_delay + 1) begin
          chr_ack = 1'b1; chr_rdata = cd;
        end
      end
      if (k >= 1 && !busy && !chr_rd && !chr_wr) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      chr_ack = 1'b0; read_request = 1'b0; write_request = 1'b0;
      if (inject && k == 0) begin
        write_request = 1'b1; wdata = inj_d;
      end
    end
    if (!done) begin
      r_timeout = 1'b1;
      checks++; failures++;
      $display("FAIL access_timeout addr=%h still busy after 300 cycles", a);
      chr_ack = 1'b0; read_request = 1'b0; write_request = 1'b0;
    end
  endtask

  task automatic wr_access(input logic [13:0] a, input logic [7:0] d);
    access(a, d, 1'b1, 1'b0, 0, 8'h00, 1'b0, 8'h00);
    model_write(a, d, mirror_mode);
  endtask

  task automatic rd_access(input logic [13:0] a);
    access(a, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (chr_rd !== 1'b0 || chr_wr !== 1'b0) begin failures++; $display("FAIL reset_chr_strobes got=%b%b exp=00", chr_rd, chr_wr); end
    checks++; if (chr_addr !== 13'h0 || chr_wdata !== 8'h00) begin failures++; $display("FAIL reset_chr_bus got=%h/%h exp=0000/00", chr_addr, chr_wdata); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_vertical;
    mirror_mode = 2'd1;
    wr_access(14'h2405, 8'h00);
    wr_access(14'h2005, 8'hA5);
    checks++; if (r_vcount != 0 || r_busy_seen != 1'b1) begin failures++; $display("FAIL vert_write_handshake got vcount=%0d busy=%b exp vcount=0 busy=1", r_vcount, r_busy_seen); end
    rd_access(14'h2805);
    checks++; if (r_vcount != 1 || r_vlat != 2) begin failures++; $display("FAIL vert_latency got count=%0d lat=%0d exp count=1 lat=2", r_vcount, r_vlat); end
    checks++; if (r_got !== 8'hA5) begin failures++; $display("FAIL vert_mirror got=%h exp=a5", r_got); end
    rd_access(14'h2405);
    checks++; if (r_got !== 8'h00) begin failures++; $display("FAIL vert_other_page got=%h exp=00", r_got); end
  endtask

  task automatic test_horizontal;
    mirror_mode = 2'd0;
    wr_access(14'h2400, 8'h3C);
    rd_access(14'h2000);
    checks++; if (r_got !== 8'h3C) begin failures++; $display("FAIL horz_mirror got=%h exp=3c", r_got); end
    rd_access(14'h3000);
    checks++; if (r_got !== 8'h3C) begin failures++; $display("FAIL horz_alias_3000 got=%h exp=3c", r_got); end
  endtask

  task automatic test_palette;
    wr_access(14'h3F01, 8'h05);
    wr_access(14'h3F10, 8'hFF);
    rd_access(14'h3F00);
    checks++; if (r_got !== 8'h3F) begin failures++; $display("FAIL pal_alias got=%h exp=3f", r_got); end
    wr_access(14'h3F11, 8'h12);
    rd_access(14'h3F01);
    checks++; if (r_got !== 8'h05) begin failures++; $display("FAIL pal_no_alias got=%h exp=05", r_got); end
    rd_access(14'h3F11);
    checks++; if (r_got !== 8'h12) begin failures++; $display("FAIL pal_3f11 got=%h exp=12", r_got); end
  endtask

  task automatic test_chr_read;
    access(14'h1234, 8'h00, 1'b0, 1'b1, 5, 8'h77, 1'b0, 8'h00);
    checks++; if (r_req != 6 || !r_addr_ok) begin failures++; $display("FAIL chr_req_window got cycles=%0d addr_ok=%b exp cycles=6 addr_ok=1", r_req, r_addr_ok); end
    checks++; if (r_got !== 8'h77 || r_vcount != 1) begin failures++; $display("FAIL chr_rdata got=%h count=%0d exp=77 count=1", r_got, r_vcount); end
    checks++; if (r_vlat != 7) begin failures++; $display("FAIL chr_valid_timing got=%0d exp=7", r_vlat); end
    checks++; if (chr_rd !== 1'b0) begin failures++; $display("FAIL chr_rd_release got=%b exp=0", chr_rd); end
  endtask

  task automatic test_collision;
    mirror_mode = 2'd0;
    wr_access(14'h2000, 8'h11);
    rd_access(14'h2000);
    access(14'h2001, 8'h5A, 1'b1, 1'b1, 0, 8'h00, 1'b0, 8'h00);
    model_write(14'h2001, 8'h5A, mirror_mode);
    checks++; if (r_vcount != 0) begin failures++; $display("FAIL collision_no_valid got=%0d exp=0", r_vcount); end
    checks++; if (rdata !== 8'h11) begin failures++; $display("FAIL collision_rdata_hold got=%h exp=11", rdata); end
    rd_access(14'h2001);
    checks++; if (r_got !== 8'h5A) begin failures++; $display("FAIL collision_write got=%h exp=5a", r_got); end
    access(14'h2001, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b1, 8'hEE);
    checks++; if (r_got !== 8'h5A || r_vcount != 1) begin failures++; $display("FAIL busy_strobe_read got=%h count=%0d exp=5a count=1", r_got, r_vcount); end
    rd_access(14'h2001);
    checks++; if (r_got !== 8'h5A) begin failures++; $display("FAIL busy_strobe_ignored got=%h exp=5a", r_got); end
  endtask

  task automatic test_chr_write;
    access(14'h0100, 8'hC3, 1'b1, 1'b0, 2, 8'h00, 1'b0, 8'h00);
`ifdef CHR_RAM_EN
    checks++; if (!r_wr_seen || r_req != 3 || !r_addr_ok) begin failures++; $display("FAIL chr_write_hs got wr=%b cycles=%0d exp wr=1 cycles=3", r_wr_seen, r_req); end
`else
    checks++; if (r_wr_seen) begin failures++; $display("FAIL rom_chr_wr got=1 exp=0"); end
    checks++; if (r_busy_seen) begin failures++; $display("FAIL rom_write_busy got=1 exp=0"); end
`endif
    checks++; if (r_vcount != 0) begin failures++; $display("FAIL chr_write_valid got=%0d exp=0", r_vcount); end
  endtask

  task automatic test_random;
    bit         known;
    logic [7:0] exp, d, cd;
    logic [13:0] a;
    int sel, delay;
    for (int i = 0; i < 32; i++) begin
      d = 8'($urandom);
      wr_access(14'h3F00 + 14'(i), d);
    end
    for (int i = 0; i < 150; i++) begin
      mirror_mode = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0)
        a = 14'h3F00 | 14'($urandom_range(0, 255));
      else
        a = 14'h2000 | 14'($urandom_range(0, 3) << 10) | 14'($urandom_range(0, 7))
            | 14'($urandom_range(0, 1) << 12);
      if (sel == 0) begin
        delay = $urandom_range(0, 4);
        cd = 8'($urandom);
        a = 14'($urandom_range(0, 14'h1FFF));
        access(a, 8'h00, 1'b0, 1'b1, delay, cd, 1'b0, 8'h00);
        checks++;
        if (r_got !== cd || r_vlat != delay + 2 || r_req != delay + 1 || !r_addr_ok) begin
          failures++;
          $display("FAIL rand_chr_read addr=%h got=%h lat=%0d req=%0d exp=%h lat=%0d req=%0d", a, r_got, r_vlat, r_req, cd, delay + 2, delay + 1);
        end
      end else if (sel <= 2) begin
        d = 8'($urandom);
        wr_access(a, d);
        checks++;
        if (r_vcount != 0 || !r_busy_seen) begin failures++; $display("FAIL rand_write addr=%h got vcount=%0d busy=%b exp vcount=0 busy=1", a, r_vcount, r_busy_seen); end
      end else begin
        model_read(a, mirror_mode, known, exp);
        rd_access(a);
        checks++;
        if (r_vcount != 1 || r_vlat != 2) begin failures++; $display("FAIL rand_read_latency addr=%h got count=%0d lat=%0d exp count=1 lat=2", a, r_vcount, r_vlat); end
        if (known) begin
          checks++;
          if (r_got !== exp) begin failures++; $display("FAIL rand_read addr=%h mode=%0d got=%h exp=%h", a, mirror_mode, r_got, exp); end
        end
      end
    end
  endtask

  task automatic test_reset_chr;
    bit saw_valid;
    @(posedge clk); #1;
    addr = 14'h0ABC; read_request = 1'b1;
    @(posedge clk); #1 read_request = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (chr_rd !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rst_chr_pending got rd=%b busy=%b exp rd=1 busy=1", chr_rd, busy); end
    #5 rst = 1'b0;
    #1;
    checks++; if (chr_rd !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_chr_async got rd=%b busy=%b exp rd=0 busy=0", chr_rd, busy); end
    @(posedge clk); #1 rst = 1'b1;
    saw_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rd_valid || busy) saw_valid = 1'b1;
    end
    checks++; if (saw_valid) begin failures++; $display("FAIL rst_chr_no_valid got activity=1 exp=0"); end
  endtask

  initial begin
    rst = 1'b0;
    addr = '0; wdata = '0; read_request = 1'b0; write_request = 1'b0;
    mirror_mode = 2'd0; chr_rdata = '0; chr_ack = 1'b0;
    for (int i = 0; i < 2048; i++) m_nt_ok[i] = 1'b0;
    for (int i = 0; i < 32; i++) m_pal_ok[i] = 1'b0;
    test_reset;
    test_vertical;
    test_horizontal;
    test_palette;
    test_chr_read;
    test_collision;
    test_chr_write;
    test_random;
    test_reset_chr;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
